// File: rtl/tx_fifo_if.sv
// Bus/shifter-facing signal bundle for the transmit FIFO.
// The master side is the APB write port plus the shifter's pop request.
interface tx_fifo_if #(parameter int WIDTH = 8);
  logic             PSEL;
  logic             PWRITE;
  logic [WIDTH-1:0] PWDATA;
  logic             read_fifo;
  logic [WIDTH-1:0] TxData;
  logic             tx_fifo_empty;
  logic             SSPTXINTR;
  logic             tx_overrun;

  modport master (output PSEL, PWRITE, PWDATA, read_fifo,
                  input  TxData, tx_fifo_empty, SSPTXINTR, tx_overrun);
  modport slave  (input  PSEL, PWRITE, PWDATA, read_fifo,
                  output TxData, tx_fifo_empty, SSPTXINTR, tx_overrun);
endinterface

// File: rtl/tx_fifo.sv
// Show-ahead transmit FIFO: APB pushes, edge-detected pops from the shifter,
// one-cycle overrun pulse when a write is dropped on a full queue.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic       PCLK,
  input  logic       CLEAR_B,
  tx_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [CW-1:0]    count;
  logic             rd_prev;
  logic             overrun_q;

  logic push_req, pop_req, push_ok, pop_ok, full, empty;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_req = bus.PSEL & bus.PWRITE;
  assign pop_req  = bus.read_fifo & ~rd_prev;
  assign pop_ok   = pop_req & ~empty;
  // A full queue still takes a write when the head leaves in the same cycle.
  assign push_ok  = push_req & (~full | pop_ok);

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      // History starts high so a level already asserted at release is not an edge.
      rd_prev   <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      rd_prev   <= bus.read_fifo;
      overrun_q <= push_req & ~push_ok;
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      if (push_ok && !pop_ok)      count <= count + CW'(1);
      else if (pop_ok && !push_ok) count <= count - CW'(1);
    end
  end

  always_ff @(posedge PCLK) begin
    if (push_ok) mem[wptr] <= bus.PWDATA;
  end

  assign bus.TxData        = empty ? '0 : mem[rptr];
  assign bus.tx_fifo_empty = empty;
  assign bus.SSPTXINTR     = full;
  assign bus.tx_overrun    = overrun_q;
endmodule
